// File: rtl/sigdel_pkg.sv
// Shared constants and saturation helper for the second-order sigma-delta modulator.
package sigdel_pkg;

    localparam int unsigned BIT_LEN = 16;
    localparam int unsigned ACC_W   = BIT_LEN + 4;
    localparam int unsigned MID     = 1 << (BIT_LEN - 1);

    // Signed add clamped to the w-bit two's-complement range; never wraps.
    function automatic longint sat_add(input longint a, input longint b, input int unsigned w);
        longint sum;
        longint hi;
        longint lo;
        sum = a + b;
        hi  = (longint'(1) <<< (w - 1)) - 1;
        lo  = -(longint'(1) <<< (w - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/sigdel_integ.sv
// Single saturating integrator stage: clear has priority over accumulate.
module sigdel_integ
    import sigdel_pkg::*;
#(
    parameter int unsigned ACCW = ACC_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   clr_i,
    input  logic signed [ACCW:0]   in_i,
    output logic signed [ACCW-1:0] acc_o
);

    logic signed [ACCW-1:0] acc_q;
    logic signed [ACCW-1:0] acc_d;
    logic signed [63:0]     sum;

    always_comb begin
        sum   = sat_add(longint'(acc_q), longint'(in_i), ACCW);
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum[ACCW-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/sigdel_mod.sv
// Second-order CIFB sigma-delta modulator: PCM samples in via valid/ready, 1-bit stream out.
module sigdel_mod
    import sigdel_pkg::*;
#(
    parameter int unsigned BITLEN = BIT_LEN,
    parameter int unsigned OSR    = 64,
    parameter int unsigned ACCW   = BITLEN + 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [BITLEN-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              dout,
    output logic              underrun,
    input  logic              clr_underrun
);

    localparam int unsigned           CNTW     = $clog2(OSR);
    localparam logic [CNTW-1:0]       CNT_LAST = CNTW'(OSR - 1);
    localparam logic [BITLEN-1:0]     MID_CODE = {1'b1, {(BITLEN-1){1'b0}}};
    localparam logic signed [ACCW:0]  MID_S    = {{(ACCW+1-BITLEN){1'b0}}, MID_CODE};

    logic [CNTW-1:0]        osr_cnt_q, osr_cnt_d;
    logic [BITLEN-1:0]      hold_q, hold_d;
    logic                   dout_q, dout_d;
    logic                   underrun_q, underrun_d;
    logic signed [ACCW-1:0] int1, int2;
    logic signed [ACCW:0]   xs, fb, in1, in2;

    always_comb begin
        s_ready   = en && (osr_cnt_q == CNT_LAST);
        osr_cnt_d = '0;
        if (en && (osr_cnt_q != CNT_LAST)) begin
            osr_cnt_d = osr_cnt_q + 1'b1;
        end
        hold_d = (s_ready && s_valid) ? s_data : hold_q;

        // A missed slot outranks a simultaneous clear.
        underrun_d = underrun_q;
        if (clr_underrun) begin
            underrun_d = 1'b0;
        end
        if (s_ready && !s_valid) begin
            underrun_d = 1'b1;
        end

        // Offset-binary to two's complement: invert MSB, then sign-extend.
        xs  = {{(ACCW+1-BITLEN){~hold_q[BITLEN-1]}}, ~hold_q[BITLEN-1], hold_q[BITLEN-2:0]};
        fb  = dout_q ? MID_S : -MID_S;
        in1 = xs - fb;
        in2 = {int1[ACCW-1], int1} - fb;

        // Idle toggling keeps the filtered output at mid-scale while disabled.
        dout_d = en ? ~int2[ACCW-1] : ~dout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osr_cnt_q  <= '0;
            hold_q     <= MID_CODE;
            dout_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            osr_cnt_q  <= osr_cnt_d;
            hold_q     <= hold_d;
            dout_q     <= dout_d;
            underrun_q <= underrun_d;
        end
    end

    sigdel_integ #(
        .ACCW (ACCW)
    ) u_int1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (en),
        .clr_i  (!en),
        .in_i   (in1),
        .acc_o  (int1)
    );

    sigdel_integ #(
        .ACCW (ACCW)
    ) u_int2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (en),
        .clr_i  (!en),
        .in_i   (in2),
        .acc_o  (int2)
    );

    assign dout     = dout_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_sigdel_mod.sv
// Self-checking bench for sigdel_mod: cycle model plus density, handshake and reset checks.
module tb_sigdel_mod;

    localparam int unsigned BITLEN = 16;
    localparam int unsigned OSR    = 64;
    localparam int unsigned ACCW   = 20;
    localparam longint      MIDV   = 32768;
    localparam longint      LIM_HI = 524287;
    localparam longint      LIM_LO = -524288;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b1;
    logic        en           = 1'b0;
    logic [15:0] s_data       = 16'h8000;
    logic        s_valid      = 1'b0;
    logic        clr_underrun = 1'b0;
    logic        s_ready;
    logic        dout;
    logic        underrun;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model state, plain integers.
    int     m_cnt;
    longint m_hold;
    longint m_i1;
    longint m_i2;
    bit     m_dout;
    bit     m_und;

    logic [15:0] rom [1024];

    always #5 clk = ~clk;

    sigdel_mod #(
        .BITLEN (BITLEN),
        .OSR    (OSR),
        .ACCW   (ACCW)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .dout         (dout),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > LIM_HI) return LIM_HI;
        if (v < LIM_LO) return LIM_LO;
        return v;
    endfunction

    function automatic bit m_ready();
        return (rst_n === 1'b1) && (en === 1'b1) && (m_cnt == int'(OSR) - 1);
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_hold = MIDV;
        m_i1   = 0;
        m_i2   = 0;
        m_dout = 1'b0;
        m_und  = 1'b0;
    endtask

    task automatic model_edge();
        bit     rdy;
        longint xs;
        longint fb;
        longint n1;
        longint n2;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rdy = m_ready();
        if (en) begin
            xs     = m_hold - MIDV;
            fb     = m_dout ? MIDV : -MIDV;
            n1     = clamp(m_i1 + xs - fb);
            n2     = clamp(m_i2 + m_i1 - fb);
            m_dout = (m_i2 >= 0);
            m_i1   = n1;
            m_i2   = n2;
            m_cnt  = (m_cnt + 1) % int'(OSR);
        end else begin
            m_i1   = 0;
            m_i2   = 0;
            m_dout = !m_dout;
            m_cnt  = 0;
        end
        if (rdy && s_valid) m_hold = longint'(s_data);
        if (rdy && !s_valid) m_und = 1'b1;
        else if (clr_underrun) m_und = 1'b0;
    endtask

    // One clock: check the combinational ready, advance, check registered outputs.
    task automatic tick();
        check_eq("s_ready", 32'(s_ready), 32'(m_ready()));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("dout", 32'(dout), 32'(m_dout));
        check_eq("underrun", 32'(underrun), 32'(m_und));
    endtask

    task automatic run_cycles(input int n, input bit chk_gap, output int ones);
        int last;
        last = -1;
        ones = 0;
        for (int c = 0; c < n; c++) begin
            if (chk_gap && s_ready) begin
                if (last >= 0) check_eq("ready_gap", 32'(c - last), 32'(OSR));
                last = c;
            end
            tick();
            ones += int'(dout);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!s_ready && k < 4 * int'(OSR)) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(s_ready), 32'd1);
    endtask

    task automatic check_range(input string tag, input int v, input int lo, input int hi);
        check_eq($sformatf("%s ones=%0d range=%0d..%0d", tag, v, lo, hi),
                 32'(v >= lo && v <= hi), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ones;
        int k;
        int idx;
        bit prev;
        bit exp_t;
        bit hs;

        for (int i = 0; i < 1024; i++) begin
            rom[i] = 16'(int'(32768.0 + 24576.0 * $sin(6.283185307179586 * real'(i) / 1024.0)));
        end

        // Reset state
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_ready", 32'(s_ready), 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        en      = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h8000;

        // Mid-scale: 50 % density, one-cycle ready pulses every OSR clocks
        run_cycles(256, 1'b1, ones);
        run_cycles(4096, 1'b1, ones);
        check_range("dens_8000", ones, 2044, 2052);

        s_data = 16'hC000;
        run_cycles(512, 1'b0, ones);
        run_cycles(8192, 1'b0, ones);
        check_range("dens_c000", ones, 6128, 6160);

        s_data = 16'h4000;
        run_cycles(512, 1'b0, ones);
        run_cycles(8192, 1'b0, ones);
        check_range("dens_4000", ones, 2032, 2064);

        // Underrun: set, clear, and set winning over clear
        s_data = 16'h8000;
        wait_ready("und_slot1");
        s_valid = 1'b0;
        s_data  = 16'h3000;
        tick();
        check_eq("und_set", 32'(underrun), 32'd1);
        s_valid      = 1'b1;
        s_data       = 16'h8000;
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        check_eq("und_clr", 32'(underrun), 32'd0);
        wait_ready("und_slot2");
        s_valid      = 1'b0;
        clr_underrun = 1'b1;
        tick();
        check_eq("und_set_wins", 32'(underrun), 32'd1);
        s_valid = 1'b1;
        tick();
        clr_underrun = 1'b0;
        check_eq("und_clr2", 32'(underrun), 32'd0);

        // Full-scale overload, then recovery to mid-scale
        s_data = 16'hFFFF;
        run_cycles(10000, 1'b0, ones);
        s_data = 16'h8000;
        wait_ready("recov_slot");
        tick();
        run_cycles(200, 1'b0, ones);
        run_cycles(2048, 1'b0, ones);
        check_range("dens_recov", ones, 1004, 1044);

        // Handshake coincident with en falling, then idle toggling
        wait_ready("enfall_slot");
        en = 1'b0;
        #1;
        check_eq("hs_en_fall", 32'(s_ready), 32'd0);
        for (int c = 0; c < 100; c++) begin
            prev  = dout;
            exp_t = !prev;
            check_eq("idle_noready", 32'(s_ready), 32'd0);
            tick();
            check_eq("idle_toggle", 32'(dout), 32'(exp_t));
        end
        en = 1'b1;
        k  = 0;
        while (!s_ready && k < 4 * int'(OSR)) begin
            tick();
            k++;
        end
        // Cycles with en high up to and including the first slot.
        check_eq("en_to_ready", 32'(k + 1), 32'(OSR));
        run_cycles(256, 1'b1, ones);
        run_cycles(2048, 1'b1, ones);
        check_range("dens_resume", ones, 1004, 1044);

        // Sine stream with sporadic gaps and an asynchronous reset mid-sample
        idx    = 0;
        s_data = rom[0];
        for (int c = 0; c < 3000; c++) begin
            hs = s_ready && s_valid;
            tick();
            if (hs) begin
                idx    = (idx + 16) % 1024;
                s_data = rom[idx];
            end
            s_valid = ($urandom_range(0, 15) != 0);
            if (c == 1500) begin
                #3 rst_n = 1'b0;
                model_reset();
                #1;
                check_eq("arst_dout", 32'(dout), 32'd0);
                check_eq("arst_ready", 32'(s_ready), 32'd0);
                check_eq("arst_underrun", 32'(underrun), 32'd0);
                for (int r = 0; r < 3; r++) tick();
                s_valid = 1'b1;
                #2 rst_n = 1'b1;
                k = 0;
                while (!s_ready && k < 4 * int'(OSR)) begin
                    tick();
                    k++;
                end
                check_eq("rst_to_ready", 32'(k), 32'(OSR - 1));
            end
        end

        // Randomised traffic: data in the stable range, gaps, clears, enable drops
        for (int c = 0; c < 3000; c++) begin
            s_data       = 16'($urandom_range(16'h1000, 16'hF000));
            s_valid      = ($urandom_range(0, 9) != 0);
            clr_underrun = ($urandom_range(0, 15) == 0);
            en           = !((c % 500) >= 450 && (c % 500) < 470);
            tick();
        end
        en           = 1'b1;
        clr_underrun = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
